// File: rtl/mips_mem_if.sv
// -----------------------------------------------------------------------------
// mips_mem_if
// Request/response bus between a MIPS core (master) and a word-addressed
// memory responder (slave).
//   req_valid  : core presents a request
//   req_ready  : responder can accept a request this cycle
//   req_addr   : word address (byte address [31:2])
//   req_wdata  : store data
//   req_we     : byte write mask, 4'b0000 = read
//   resp_valid : one-cycle pulse completing a request
//   resp_rdata : word data returned with resp_valid
//   resp_excpt : request address was out of range (qualified by resp_valid)
// -----------------------------------------------------------------------------
interface mips_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic [29:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_we;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_excpt;

    modport master (
        output req_valid, req_addr, req_wdata, req_we,
        input  req_ready, resp_valid, resp_rdata, resp_excpt
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we,
        output req_ready, resp_valid, resp_rdata, resp_excpt
    );
endinterface

// File: rtl/mips_mem_responder.sv
// -----------------------------------------------------------------------------
// mips_mem_responder
// Fixed-latency word memory for a MIPS core. A request accepted on edge N is
// completed by a one-cycle resp_valid pulse in the cycle after edge N+LATENCY.
// Writes commit on the BUSY->RESP edge; the response carries the word as it
// stands after that commit. Addresses outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS)
// (modular 30-bit arithmetic) are not written and answer with resp_excpt=1.
//
// Ports:
//   clk   : clock, rising edge
//   rst_b : asynchronous active-low reset (storage contents are not reset)
//   bus   : mips_mem_if.slave request/response bus
//
// Parameters:
//   BASE_ADDR   : word address mapped to storage index 0
//   DEPTH_WORDS : number of 32-bit words, power of two, >= 2
//   LATENCY     : accept-to-response cycles, 1..15
//
// Build option:
//   MIPS_MEM_RESP_BYTE_EN : when defined, only lanes with req_we[i]=1 are
//                           written; otherwise any nonzero req_we writes the
//                           whole word.
// -----------------------------------------------------------------------------
module mips_mem_responder #(
    parameter logic [29:0] BASE_ADDR   = 30'h00100000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst_b,
    mips_mem_if.slave       bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    // Merge store data into the existing word according to the byte mask.
    function automatic logic [31:0] merge_word(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] res;
`ifdef MIPS_MEM_RESP_BYTE_EN
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
`else
        if (be != 4'b0000) begin
            res = new_w;
        end else begin
            res = old_w;
        end
`endif
        return res;
    endfunction

    state_t      state_r, state_nx_s;
    logic [3:0]  cnt_r, cnt_nx_s;
    logic        ready_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_excpt_r;
    logic [29:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  we_r;
    logic [31:0] mem_r [DEPTH_WORDS];

    logic          accept_s;
    logic          commit_s;
    logic [29:0]   off_s;
    logic          in_range_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   merged_s;
    logic          wr_en_s;

    // ready_r is only ever high outside BUSY, so a plain AND is the handshake.
    assign accept_s   = bus.req_valid & ready_r;
    assign commit_s   = (state_r == BUSY) && (cnt_r == 4'd0);
    // Modular offset: addresses below BASE_ADDR wrap to huge values and fail.
    assign off_s      = addr_r - BASE_ADDR;
    assign in_range_s = ({1'b0, off_s} < 31'(DEPTH_WORDS));
    assign idx_s      = off_s[AW-1:0];
    assign merged_s   = merge_word(mem_r[idx_s], wdata_r, we_r);
    assign wr_en_s    = commit_s && in_range_s && (we_r != 4'b0000);

    assign bus.req_ready  = ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_excpt = resp_excpt_r;

    // Next-state and latency counter logic.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = BUSY;
                    cnt_nx_s   = CNT_LOAD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_nx_s = RESP;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (accept_s) begin
                    state_nx_s = BUSY;
                    cnt_nx_s   = CNT_LOAD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = 4'd0;
            end
        endcase
    end

    // State, counter and registered handshake/response outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            ready_r      <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_excpt_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            // Ready for the coming cycle is known from where the FSM is going.
            ready_r      <= (state_nx_s != BUSY);
            resp_valid_r <= commit_s;
            resp_rdata_r <= (commit_s && in_range_s) ? merged_s : 32'd0;
            resp_excpt_r <= commit_s && !in_range_s;
        end
    end

    // Request capture; inputs are only looked at on an accept edge.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            addr_r  <= 30'd0;
            wdata_r <= 32'd0;
            we_r    <= 4'b0000;
        end else if (accept_s) begin
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
            we_r    <= bus.req_we;
        end
    end

    // Storage array; deliberately not reset so contents survive rst_b.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mips_mem_responder
// Directed-vector bench for mips_mem_responder. u_dut uses LATENCY=2 for the
// functional, range and reset vectors; u_dut1 uses LATENCY=1 for the held
// req_valid throughput vector.
// -----------------------------------------------------------------------------
module tb_mips_mem_responder;

    localparam logic [29:0] BASE  = 30'h00100000;
    localparam int          DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_b;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mips_mem_if bus();
    mips_mem_if bus1();

    mips_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    mips_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus1)
    );

    // Count one comparison and report it if it does not match.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on u_dut: checks handshake, latency, response and quiet cycle.
    task automatic xfer(input string tag, input logic [29:0] a, input logic [31:0] wd,
                        input logic [3:0] we, input logic [31:0] exp_d, input logic exp_x);
        int lat;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_we    = we;
        check_val({tag, "_rdy"}, {31'd0, bus.req_ready}, 32'd1);
        tick();
        // Garbage on the bus while idle must be ignored.
        bus.req_valid = 1'b0;
        bus.req_addr  = ~a;
        bus.req_wdata = 32'h5A5A0FF0;
        bus.req_we    = 4'hF;
        check_val({tag, "_busy_rdy"}, {31'd0, bus.req_ready}, 32'd0);
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 16) begin
            tick();
            lat++;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'd2);
        check_val({tag, "_rdata"}, bus.resp_rdata, exp_d);
        check_val({tag, "_excpt"}, {31'd0, bus.resp_excpt}, {31'd0, exp_x});
        tick();
        check_val({tag, "_vld_off"}, {31'd0, bus.resp_valid}, 32'd0);
        check_val({tag, "_rdata_off"}, bus.resp_rdata, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_merge;
        int          seen;
        bit          odd;

        rst_b = 1'b0;
        bus.req_valid  = 1'b0;  bus.req_addr  = 30'd0;  bus.req_wdata  = 32'd0;  bus.req_we  = 4'd0;
        bus1.req_valid = 1'b0;  bus1.req_addr = 30'd0;  bus1.req_wdata = 32'd0;  bus1.req_we = 4'd0;
        repeat (2) tick();

        // Reset values
        check_val("rst_rdy",   {31'd0, bus.req_ready},  32'd0);
        check_val("rst_vld",   {31'd0, bus.resp_valid}, 32'd0);
        check_val("rst_rdata", bus.resp_rdata,          32'd0);
        check_val("rst_excpt", {31'd0, bus.resp_excpt}, 32'd0);
        rst_b = 1'b1;
        tick();
        check_val("post_rst_rdy", {31'd0, bus.req_ready}, 32'd1);

        // Basic write / read-back
        xfer("pre_b3",  BASE + 30'd3, 32'h12345678, 4'hF, 32'h12345678, 1'b0);
        xfer("wr_b5",   BASE + 30'd5, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0);
        xfer("rd_b5",   BASE + 30'd5, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);

        // Partial byte mask
`ifdef MIPS_MEM_RESP_BYTE_EN
        exp_merge = 32'hDE22BE44;
`else
        exp_merge = 32'h11223344;
`endif
        xfer("wr_mask", BASE + 30'd5, 32'h11223344, 4'b0101, exp_merge, 1'b0);
        xfer("rd_mask", BASE + 30'd5, 32'h0,        4'h0,    exp_merge, 1'b0);

        // Out-of-range: no write to the aliasing index, zero data, exception
        xfer("pre_b0",    BASE,                   32'h0000A000, 4'hF, 32'h0000A000, 1'b0);
        xfer("pre_btop",  BASE + 30'(DEPTH - 1),  32'h0000B3FF, 4'hF, 32'h0000B3FF, 1'b0);
        xfer("rd_hi_oor", BASE + 30'(DEPTH),      32'h0,        4'h0, 32'h0,        1'b1);
        xfer("rd_lo_oor", BASE - 30'd1,           32'h0,        4'h0, 32'h0,        1'b1);
        xfer("wr_hi_oor", BASE + 30'(DEPTH),      32'hFFFFFFFF, 4'hF, 32'h0,        1'b1);
        xfer("wr_lo_oor", BASE - 30'd1,           32'hFFFFFFFF, 4'hF, 32'h0,        1'b1);
        xfer("chk_b0",    BASE,                   32'h0,        4'h0, 32'h0000A000, 1'b0);
        xfer("chk_btop",  BASE + 30'(DEPTH - 1),  32'h0,        4'h0, 32'h0000B3FF, 1'b0);

        // Reset one cycle after accepting a write
        bus.req_valid = 1'b1;
        bus.req_addr  = BASE + 30'd3;
        bus.req_wdata = 32'hCAFEF00D;
        bus.req_we    = 4'hF;
        tick();
        bus.req_valid = 1'b0;
        rst_b = 1'b0;
        #1;
        check_val("mid_rst_rdy", {31'd0, bus.req_ready}, 32'd0);
        check_val("mid_rst_vld", {31'd0, bus.resp_valid}, 32'd0);
        tick();
        rst_b = 1'b1;
        tick();
        check_val("rel_rdy", {31'd0, bus.req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.resp_valid === 1'b1) seen++;
            tick();
        end
        check_val("rst_no_resp", 32'(seen), 32'd0);
        xfer("chk_b3", BASE + 30'd3, 32'h0, 4'h0, 32'h12345678, 1'b0);

        // Held req_valid with LATENCY=1: one accept every other edge
        check_val("thr_rdy0", {31'd0, bus1.req_ready}, 32'd1);
        bus1.req_valid = 1'b1;
        bus1.req_addr  = BASE + 30'd7;
        bus1.req_wdata = 32'hA5A5A5A5;
        bus1.req_we    = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            odd = (i % 2) == 1;
            check_val($sformatf("thr_rdy%0d", i), {31'd0, bus1.req_ready}, {31'd0, odd});
            check_val($sformatf("thr_vld%0d", i), {31'd0, bus1.resp_valid}, {31'd0, odd});
            check_val($sformatf("thr_dat%0d", i), bus1.resp_rdata, odd ? 32'hA5A5A5A5 : 32'd0);
        end
        bus1.req_valid = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_mem_responder.md
MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 30'h00100000, the word address that maps to storage index 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, the number of 32-bit storage words; it is a power of two and at least 2.
REQ-003 SHALL have parameter LATENCY, default 2, the number of cycles from request accept to response; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_b, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1 bit: the core presents a request.
REQ-007 SHALL have port req_ready, output, 1 bit: the responder can accept a request this cycle.
REQ-008 SHALL have port req_addr, input, 30 bits: word address, byte address [31:2].
REQ-009 SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 SHALL have port req_we, input, 4 bits: byte write mask, bit i covers byte lane [8i+7:8i]; 4'b0000 means a read.
REQ-011 SHALL have port resp_valid, output, 1 bit: one-cycle pulse that completes a request.
REQ-012 SHALL have port resp_rdata, output, 32 bits: word data returned with resp_valid.
REQ-013 SHALL have port resp_excpt, output, 1 bit: the request address was out of range; qualified by resp_valid.

Function
REQ-014 SHALL implement the states IDLE, BUSY and RESP.
REQ-015 SHALL drive req_ready=1 in IDLE and RESP and req_ready=0 in BUSY.
REQ-016 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, latching addr, wdata and we.
REQ-017 SHALL, on accept, enter BUSY and load a 4-bit counter with LATENCY-1.
REQ-018 SHALL, in BUSY, go to RESP on the next edge when the counter is 0, and otherwise decrement the counter.
REQ-019 SHALL assert resp_valid exactly in the single cycle after edge N+LATENCY, where N is the accept edge.
REQ-020 SHALL leave RESP after one cycle: to BUSY if a new request is accepted on that edge, otherwise to IDLE. This gives back-to-back throughput of one request per LATENCY+1 cycles.
REQ-021 SHALL treat an address as in range when the 30-bit modular value (addr - BASE_ADDR) < DEPTH_WORDS, and index storage with its low log2(DEPTH_WORDS) bits.
REQ-022 SHALL, for an in-range request, commit the write on the BUSY-to-RESP edge and drive resp_rdata with the stored word after that commit (read-after-write value); resp_excpt=0.
REQ-023 SHALL, for an out-of-range request, perform no write and drive resp_rdata=0 and resp_excpt=1.
REQ-024 SHALL hold resp_rdata and resp_excpt at 0 whenever resp_valid=0.
REQ-025 SHALL ignore req_addr, req_wdata and req_we in every cycle without an accept.

Reset
REQ-026 SHALL, while rst_b=0, immediately force state IDLE, counter 0, resp_valid=0, resp_rdata=0, resp_excpt=0 and req_ready=0.
REQ-027 SHALL drive req_ready=1 from the first rising edge after rst_b deasserts.
REQ-028 SHALL, when reset is asserted mid-operation, discard the pending request, perform no uncommitted write and produce no response.
REQ-029 SHALL NOT reset the storage contents.

Configuration
REQ-030 SHALL, with MIPS_MEM_RESP_BYTE_EN defined, write only the byte lanes whose req_we bit is 1 and preserve all other lanes.
REQ-031 SHALL, with MIPS_MEM_RESP_BYTE_EN undefined, write the full 32-bit word whenever req_we is nonzero.

Verification
REQ-032 SHALL cover: LATENCY=2, accept at edge N of write addr=BASE+5, wdata=32'hDEADBEEF, we=4'hF -> resp_valid high only after edge N+2, rdata=32'hDEADBEEF, excpt=0; a later read of BASE+5 returns 32'hDEADBEEF.
REQ-033 SHALL cover: word BASE+5 = 32'hDEADBEEF, then write wdata=32'h11223344, we=4'b0101 -> with BYTE_EN defined rdata=32'hDE22BE44; with BYTE_EN undefined rdata=32'h11223344.
REQ-034 SHALL cover: read addr=BASE+DEPTH_WORDS, and separately addr=BASE-1 -> resp_excpt=1, rdata=0, storage unchanged.
REQ-035 SHALL cover: req_valid held at 1 with LATENCY=1 -> accepts on alternate edges, resp_valid pulses every 2 cycles, req_ready=0 in BUSY.
REQ-036 SHALL cover: rst_b pulsed low one cycle after accepting a write of 32'hCAFEF00D to BASE+3 -> no resp_valid; BASE+3 keeps its prior value; req_ready=1 on the first edge after release.
